vec_lane_sequencer: RTL and testbench

VEC_LANE_SEQUENCER -- requirements
Module: vec_lane_sequencer

---
 rtl/vec_lane_sequencer.sv | 179 +++++++++++++++++
 tb/tb_vec_lane_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_lane_sequencer.sv
`default_nettype none
// vec_lane_sequencer: steps a latched operand pair through a shared lane ALU one element per cycle,
// accumulating flags and committing the whole result vector together with a one-cycle done pulse.
module vec_lane_sequencer #(
  parameter int N = 24,
  parameter int M = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic         modeSel,
  input  logic [3:0]   aluControl,
  input  logic [N*M-1:0] srcA,
  input  logic [N*M-1:0] srcB,
  output logic [N-1:0] lane_a,
  output logic [N-1:0] lane_b,
  output logic [3:0]   lane_ctrl,
  output logic         lane_valid,
  input  logic [N-1:0] lane_result,
  input  logic         lane_neg,
  input  logic         lane_zero,
  output logic [N*M-1:0] result,
  output logic         neg_any,
  output logic         zero_all,
  output logic         done,
  output logic         busy,
  input  logic         flush
);

  localparam int IDXW = (M > 1) ? $clog2(M) : 1;
  localparam logic [IDXW-1:0] c_last_vec = IDXW'(M - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDXW-1:0]   r_idx;
  logic [IDXW-1:0]   r_last;
  logic [N*M-1:0]    r_a;
  logic [N*M-1:0]    r_b;
  logic [3:0]        r_ctrl;
  logic              r_zacc;
  logic              r_nacc;
  logic              r_neg;
  logic              r_zero;
  logic              w_accept;
  logic              w_step;
  logic              w_commit;
  logic [N-1:0]      w_a_el [M];
  logic [N-1:0]      w_b_el [M];

  assign w_accept = (r_state == IDLE) && start_valid && !flush;
  assign w_step   = (r_state == RUN) && !flush;
  assign w_commit = w_step && (r_idx == r_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    start_ready = 1'b0;
    busy        = 1'b0;
    lane_valid  = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        start_ready = 1'b1;
        if (w_accept) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        busy       = 1'b1;
        lane_valid = 1'b1;
        if (w_commit) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    // Abort wins over acceptance and completion alike.
    if (flush) begin
      w_state_nxt = IDLE;
    end
  end

  assign lane_a    = lane_valid ? w_a_el[r_idx] : '0;
  assign lane_b    = lane_valid ? w_b_el[r_idx] : '0;
  assign lane_ctrl = lane_valid ? r_ctrl : '0;
  assign neg_any   = r_neg;
  assign zero_all  = r_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_ctrl <= '0;
      r_idx  <= '0;
      r_last <= '0;
      r_zacc <= 1'b1;
      r_nacc <= 1'b0;
      r_neg  <= 1'b0;
      r_zero <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a    <= srcA;
        r_b    <= srcB;
        r_ctrl <= aluControl;
        r_idx  <= '0;
        r_last <= modeSel ? c_last_vec : '0;
        r_zacc <= 1'b1;
        r_nacc <= 1'b0;
      end else if (w_step) begin
        r_zacc <= r_zacc & lane_zero;
        r_nacc <= r_nacc | lane_neg;
        if (r_idx != r_last) begin
          r_idx <= r_idx + 1'b1;
        end
      end else if (flush) begin
        r_idx  <= '0;
        r_zacc <= 1'b1;
        r_nacc <= 1'b0;
      end
      // The final element's flags arrive in the commit cycle itself, so fold them in directly.
      if (w_commit) begin
        r_zero <= r_zacc & lane_zero;
        r_neg  <= r_nacc | lane_neg;
      end
    end
  end

  for (genvar g = 0; g < M; g++) begin : g_lane
    localparam logic [IDXW-1:0] c_idx = IDXW'(g);
    logic [N-1:0] r_sh;
    logic [N-1:0] r_res;
    logic [N-1:0] w_sh_nxt;

    assign w_a_el[g] = r_a[g*N +: N];
    assign w_b_el[g] = r_b[g*N +: N];
    assign w_sh_nxt  = (r_idx == c_idx) ? lane_result : r_sh;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_sh <= '0;
      end else if (w_step) begin
        r_sh <= w_sh_nxt;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_res <= '0;
      end else if (w_commit) begin
        r_res <= (c_idx <= r_last) ? w_sh_nxt : '0;
      end
    end

    assign result[g*N +: N] = r_res;
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_lane_sequencer.sv
`default_nettype none
// Self-checking bench for vec_lane_sequencer: table-driven operations, behavioural lane ALU,
// scoreboard popped on every done pulse, plus hand-written flush / held-request / reset sequences.
module tb_vec_lane_sequencer;
  localparam int N = 24;
  localparam int M = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start_valid = 1'b0;
  logic           start_ready;
  logic           modeSel = 1'b0;
  logic [3:0]     aluControl = '0;
  logic [N*M-1:0] srcA = '0;
  logic [N*M-1:0] srcB = '0;
  logic [N-1:0]   lane_a, lane_b;
  logic [3:0]     lane_ctrl;
  logic           lane_valid;
  logic [N-1:0]   lane_result;
  logic           lane_neg, lane_zero;
  logic [N*M-1:0] result;
  logic           neg_any, zero_all, done, busy;
  logic           flush = 1'b0;

  vec_lane_sequencer #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .modeSel(modeSel), .aluControl(aluControl), .srcA(srcA), .srcB(srcB),
    .lane_a(lane_a), .lane_b(lane_b), .lane_ctrl(lane_ctrl), .lane_valid(lane_valid),
    .lane_result(lane_result), .lane_neg(lane_neg), .lane_zero(lane_zero),
    .result(result), .neg_any(neg_any), .zero_all(zero_all), .done(done), .busy(busy),
    .flush(flush)
  );

  always #5 clk = ~clk;

  // Behavioural lane ALU: 0001 add, 0100 subtract.
  always_comb begin
    lane_result = '0;
    case (lane_ctrl)
      4'b0001: lane_result = lane_a + lane_b;
      4'b0100: lane_result = lane_a - lane_b;
      default: lane_result = '0;
    endcase
    lane_neg  = lane_result[N-1];
    lane_zero = (lane_result == '0);
  end

  typedef struct {
    logic           mode;
    logic [3:0]     ctrl;
    logic [N*M-1:0] a;
    logic [N*M-1:0] b;
    logic [N*M-1:0] res;
    logic           neg;
    logic           zero;
  } tv_t;

  typedef struct {
    logic [N*M-1:0] res;
    logic           neg;
    logic           zero;
  } exp_t;

  tv_t            tbl [6];
  exp_t           sbq [$];
  exp_t           mon_e;
  int             n_cmp = 0;
  int             n_bad = 0;
  int             n_pushed = 0;
  int             n_done = 0;
  logic [N*M-1:0] last_res = '0;
  logic           last_neg = 1'b0;
  logic           last_zero = 1'b0;
  logic [N*M-1:0] tmp;

  function automatic logic [N*M-1:0] vec6(input logic [N-1:0] e0, e1, e2, e3, e4, e5);
    return {e5, e4, e3, e2, e1, e0};
  endfunction

  function automatic void model(inout tv_t v);
    logic [N-1:0] ea, eb, r;
    v.res  = '0;
    v.neg  = 1'b0;
    v.zero = 1'b1;
    for (int i = 0; i < M; i++) begin
      if (i == 0 || v.mode) begin
        ea = v.a[i*N +: N];
        eb = v.b[i*N +: N];
        r  = (v.ctrl == 4'b0001) ? ea + eb : ea - eb;
        v.res[i*N +: N] = r;
        v.neg  = v.neg | r[N-1];
        v.zero = v.zero & (r == '0);
      end
    end
  endfunction

  task automatic chk(input string name, input logic [N*M-1:0] got, input logic [N*M-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      n_done++;
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending request");
      end else begin
        mon_e = sbq.pop_front();
        chk("result", result, mon_e.res);
        chk("neg_any", {{(N*M-1){1'b0}}, neg_any}, {{(N*M-1){1'b0}}, mon_e.neg});
        chk("zero_all", {{(N*M-1){1'b0}}, zero_all}, {{(N*M-1){1'b0}}, mon_e.zero});
      end
    end
  end

  task automatic load(input int t);
    modeSel    = tbl[t].mode;
    aluControl = tbl[t].ctrl;
    srcA       = tbl[t].a;
    srcB       = tbl[t].b;
  endtask

  task automatic push_exp(input int t);
    sbq.push_back('{tbl[t].res, tbl[t].neg, tbl[t].zero});
    last_res  = tbl[t].res;
    last_neg  = tbl[t].neg;
    last_zero = tbl[t].zero;
    n_pushed++;
  endtask

  // Called #1 after the accepting edge; done must rise after edge k+last+1.
  task automatic wait_done(input string name, input int exp_lat);
    int cyc = 0;
    while (done !== 1'b1 && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk(name, cyc, exp_lat);
    chk("ready_in_done", start_ready, 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run_op(input int t);
    @(negedge clk);
    load(t);
    start_valid = 1'b1;
    chk("ready_idle", start_ready, 1);
    @(posedge clk);
    push_exp(t);
    #1;
    start_valid = 1'b0;
    tmp = tbl[t].a;
    chk("first_lane_a", lane_a, tmp[0 +: N]);
    chk("first_lane_ctrl", lane_ctrl, tbl[t].ctrl);
    chk("run_busy", {busy, lane_valid, start_ready}, 3'b110);
    wait_done("latency", tbl[t].mode ? M : 1);
    chk("idle_after_done", {busy, start_ready}, 2'b01);
  endtask

  initial begin
    tbl[0] = '{1'b1, 4'b0001, vec6(1, 2, 3, 4, 5, 6), vec6(7, 8, 9, 10, 11, 12),
               vec6(8, 10, 12, 14, 16, 18), 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'b0100, vec6(1, 11, 22, 33, 44, 55), vec6(4, 66, 77, 88, 99, 5),
               vec6(24'hFFFFFD, 0, 0, 0, 0, 0), 1'b1, 1'b0};
    tbl[2] = '{1'b0, 4'b0100, vec6(1, 9, 9, 9, 9, 9), vec6(1, 2, 3, 4, 5, 6),
               '0, 1'b0, 1'b1};
    tbl[3] = '{1'b1, 4'b0100, vec6(10, 5, 0, 100, 7, 3), vec6(3, 5, 1, 50, 7, 4), '0, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 4'b0100, vec6(9, 8, 7, 6, 5, 4), vec6(9, 8, 7, 6, 5, 4), '0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 4'b0001, vec6(24'hFFFFFF, 1, 2, 3, 4, 5), vec6(1, 1, 1, 1, 1, 1), '0, 1'b0, 1'b0};
    for (int i = 3; i < 6; i++) model(tbl[i]);

    // Reset state.
    #12;
    chk("rst_ready_busy", {start_ready, busy, done, lane_valid}, 4'b1000);
    chk("rst_result", result, '0);
    chk("rst_flags", {neg_any, zero_all}, 2'b00);
    chk("rst_lane", {lane_a, lane_b, lane_ctrl}, '0);
    @(negedge clk);
    rst = 1'b1;

    for (int t = 0; t < 6; t++) run_op(t);

    // Flush at idx=3 of a vector operation.
    @(negedge clk);
    load(3);
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tmp = tbl[3].a;
    chk("flush_lane_a_idx3", lane_a, tmp[3*N +: N]);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_idle", {start_ready, busy, lane_valid}, 3'b100);
    chk("flush_lane_zero", lane_a, '0);
    @(negedge clk);
    flush = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("flush_result_held", result, last_res);
    chk("flush_flags_held", {neg_any, zero_all}, {last_neg, last_zero});

    // Flush beats a simultaneous start; the held request is then taken.
    @(negedge clk);
    load(2);
    start_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_prio_start", {start_ready, busy}, 2'b10);
    @(negedge clk);
    flush = 1'b0;
    @(posedge clk);
    push_exp(2);
    #1;
    start_valid = 1'b0;
    chk("start_after_flush", busy, 1);
    wait_done("latency_after_flush", 1);

    // Request held across RUN and DONE: second one accepted in first IDLE cycle.
    @(negedge clk);
    load(0);
    start_valid = 1'b1;
    @(posedge clk);
    push_exp(0);
    #1;
    load(1);
    wait_done("latency_held1", M);
    chk("held_idle_cycle", {start_ready, busy}, 2'b10);
    @(posedge clk);
    push_exp(1);
    #1;
    start_valid = 1'b0;
    chk("held_accepted", {busy, lane_ctrl}, {1'b1, 4'b0100});
    wait_done("latency_held2", 1);

    // Asynchronous reset at idx=2 of a vector op, then a fresh op.
    @(negedge clk);
    load(4);
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tmp = tbl[4].b;
    chk("rst_mid_lane_b_idx2", lane_b, tmp[2*N +: N]);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ctrl", {start_ready, busy, done, lane_valid}, 4'b1000);
    chk("arst_result", result, '0);
    chk("arst_flags_lane", {neg_any, zero_all, lane_a, lane_b, lane_ctrl}, '0);
    last_res = '0;
    last_neg = 1'b0;
    last_zero = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_op(5);

    repeat (3) @(posedge clk);
    #1;
    chk("done_count", n_done, n_pushed);
    chk("queue_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
